// File: rtl/logxy_pkg.sv
// logxy_pkg -- shared types and constants for the logxy block.
//   state_t    : controller states
//   fp_t       : IEEE-754 single-precision field view
//   lead_pos() : position of the most significant set bit of a 32-bit word
//   is_bad()   : operand class that makes log_x(y) undefined here
package logxy_pkg;

  // Field widths of the IEEE-754 single format and of the internal log value.
  localparam int WORD_W    = 32;
  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int MANT_W    = FRAC_W + 1;   // mantissa with hidden one, Q1.23
  localparam int LOG_W     = 32;           // signed log2 value, 23 fraction bits
  localparam int LOG_INT_W = LOG_W - 23;   // integer part of the log value
  localparam int CNT_W     = 5;            // wide enough for every phase counter

  localparam int               LOG_FRAC_BITS = 23;
  localparam int               DIV_BITS      = 26;
  localparam logic [WORD_W-1:0] QNAN         = 32'h7FC00000;
  localparam int               BIAS          = 127;

  typedef enum logic [2:0] {
    IDLE,
    CLASS,
    LOGY,
    LOGX,
    PRENORM,
    DIV,
    PACK,
    DONE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

  // Priority encoder: index of the highest set bit (0 when v is zero).
  function automatic logic [CNT_W-1:0] lead_pos(input logic [LOG_W-1:0] v);
    logic [CNT_W-1:0] p;
    p = '0;
    for (int i = 0; i < LOG_W; i++) begin
      if (v[i]) p = CNT_W'(i);
    end
    return p;
  endfunction

  // Negative, zero/denormal (exponent 0) and Inf/NaN (exponent all ones)
  // operands have no real logarithm in this datapath.
  function automatic logic is_bad(input fp_t f);
    return f.sign || (f.exp == '0) || (f.exp == '1);
  endfunction

endpackage

// File: rtl/logxy_log2_iter.sv
// log2_iter -- iterative log2 of a normal positive single-precision value.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load frac/exp and compute the first fraction bit this cycle
//   frac     : 23-bit fraction of the operand (hidden one is implied)
//   exp      : biased exponent of the operand
//   done     : high in the cycle that computes the last fraction bit
//   result   : signed log2 value, 23 fraction bits; complete from the
//              cycle after done until the next start
// Each cycle squares the running mantissa; a square of 2.0 or more yields
// a one bit and is halved back into [1,2). Bits come out MSB first.
module log2_iter
  import logxy_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FRAC_W-1:0] frac,
  input  logic [EXP_W-1:0]  exp,
  output logic              done,
  output logic [LOG_W-1:0]  result
);

  logic [MANT_W-1:0]        m_q;
  logic [MANT_W-1:0]        m_in;
  logic [MANT_W-1:0]        m_next;
  logic [2*MANT_W-1:0]      sq;
  logic                     bit_now;
  logic [LOG_INT_W-1:0]     int_q;
  logic [LOG_FRAC_BITS-1:0] frac_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     busy_q;
  logic                     unused_sq_lo;

  // The start cycle already iterates on the fresh operand, so 23 cycles
  // starting with start produce all 23 bits.
  assign m_in = start ? {1'b1, frac} : m_q;

  // The single multiplier: Q1.23 x Q1.23 -> Q2.46.
  assign sq = (2*MANT_W)'(m_in) * (2*MANT_W)'(m_in);

  // Truncated square is sq[47:23] (Q2.23); bit 47 carries the weight 2.0.
  assign bit_now = sq[2*MANT_W-1];
  assign m_next  = bit_now ? sq[2*MANT_W-1:MANT_W] : sq[2*MANT_W-2:MANT_W-1];
  assign unused_sq_lo = ^sq[MANT_W-2:0];

  assign done   = busy_q && (cnt_q == CNT_W'(LOG_FRAC_BITS - 1));
  // The integer part is a whole number, so the fraction bits concatenate.
  assign result = {int_q, frac_q};

  // NOTE: datapath registers are reset along with control so that every
  // output has a defined value after reset; nothing here is a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q    <= '0;
      int_q  <= '0;
      frac_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      m_q    <= m_next;
      int_q  <= {1'b0, exp} - LOG_INT_W'(BIAS);
      frac_q <= {{(LOG_FRAC_BITS-1){1'b0}}, bit_now};
      cnt_q  <= CNT_W'(1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      m_q    <= m_next;
      frac_q <= {frac_q[LOG_FRAC_BITS-2:0], bit_now};
      cnt_q  <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/logxy.sv
// logxy -- z = log_x(y) = log2(y) / log2(x) on IEEE-754 single operands.
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : operand pair present on x (base) and y (argument)
//   in_ready  : idle; a transfer happens when in_valid && in_ready on clk
//   x, y      : IEEE-754 single inputs, captured on the accepting edge
//   out_valid : z/err hold a result until out_ready is seen
//   out_ready : consumer takes the result on out_valid && out_ready
//   z         : IEEE-754 single result (truncated toward zero)
//   err       : result is the quiet NaN because an operand was invalid
// Sequence: CLASS, LOGY (23), LOGX (23), PRENORM, DIV (26), PACK, DONE.
// Invalid operands skip from CLASS straight to PACK, which writes the NaN.
module logxy
  import logxy_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] z,
  output logic              err
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;

  fp_t              x_q;
  fp_t              y_q;
  logic             bad_in;

  // Shared log2 unit
  logic             log_start;
  logic             log_done;
  fp_t              log_op;
  logic [LOG_W-1:0] log_result;
  logic [LOG_W-1:0] ly_q;

  // Pre-normalisation
  logic [LOG_W-1:0] mag_y;
  logic [LOG_W-1:0] mag_x;
  logic [CNT_W-1:0] pos_y;
  logic [CNT_W-1:0] pos_x;
  logic [LOG_W-1:0] norm_y;
  logic [LOG_W-1:0] norm_x;
  logic [EXP_W:0]   e_pre;

  // Division and packing
  logic               sign_q;
  logic [EXP_W-1:0]   e_q;
  logic [LOG_W:0]     rem_q;
  logic [LOG_W-1:0]   dsr_q;
  logic [DIV_BITS-1:0] quo_q;
  logic               rem_ge;
  logic [LOG_W:0]     rem_diff;
  logic [FRAC_W-1:0]  mant;
  logic [EXP_W-1:0]   pack_exp;
  logic               err_q;
  logic               zero_q;
  logic [WORD_W-1:0]  z_q;
  logic               unused_bits;

  // ---------------------------------------------------------------------
  // Controller: state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Phase counter restarts whenever the state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt_q <= '0;
    else if (state_d != state_q) cnt_q <= '0;
    else                        cnt_q <= cnt_q + CNT_W'(1);
  end

  // ---------------------------------------------------------------------
  // Controller: next state
  // ---------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = CLASS;
      CLASS:   state_d = bad_in ? PACK : LOGY;
      LOGY:    if (log_done) state_d = LOGX;
      LOGX:    if (log_done) state_d = PRENORM;
      PRENORM: state_d = (ly_q == '0) ? PACK : DIV;
      DIV:     if (cnt_q == CNT_W'(DIV_BITS - 1)) state_d = PACK;
      PACK:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Controller: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    log_start = 1'b0;
    unique case (state_q)
      IDLE:       in_ready  = 1'b1;
      LOGY, LOGX: log_start = (cnt_q == '0);
      DONE:       out_valid = 1'b1;
      default:    ;
    endcase
  end

  assign err = out_valid && err_q;
  assign z   = z_q;

  // ---------------------------------------------------------------------
  // Classification: x == 1.0 would divide by log2(x) == 0.
  // ---------------------------------------------------------------------
  assign bad_in = is_bad(x_q) || is_bad(y_q) || (x_q == fp_t'(32'h3F800000));

  // ---------------------------------------------------------------------
  // Shared log2 unit: y first, then x.
  // ---------------------------------------------------------------------
  assign log_op = (state_q == LOGX) ? x_q : y_q;

  log2_iter u_log2 (
    .clk    (clk),
    .rst    (rst),
    .start  (log_start),
    .frac   (log_op.frac),
    .exp    (log_op.exp),
    .done   (log_done),
    .result (log_result)
  );

  // ---------------------------------------------------------------------
  // Pre-normalisation: in PRENORM, ly_q holds Ly and log_result holds Lx.
  // Both magnitudes are shifted so their leading one sits at bit 31; the
  // shift difference moves into the exponent.
  // ---------------------------------------------------------------------
  assign mag_y  = ly_q[LOG_W-1]       ? (~ly_q + 1'b1)       : ly_q;
  assign mag_x  = log_result[LOG_W-1] ? (~log_result + 1'b1) : log_result;
  assign pos_y  = lead_pos(mag_y);
  assign pos_x  = lead_pos(mag_x);
  assign norm_y = mag_y << (CNT_W'(LOG_W - 1) - pos_y);
  assign norm_x = mag_x << (CNT_W'(LOG_W - 1) - pos_x);
  assign e_pre  = (EXP_W+1)'(BIAS) + (EXP_W+1)'(pos_y) - (EXP_W+1)'(pos_x);

  // ---------------------------------------------------------------------
  // Restoring division step. The quotient of two [1,2) values lies in
  // (0.5, 2), so the first bit is the integer bit: quo_q is Q1.25.
  // ---------------------------------------------------------------------
  assign rem_ge   = (rem_q >= {1'b0, dsr_q});
  assign rem_diff = rem_ge ? (rem_q - {1'b0, dsr_q}) : rem_q;

  // Quotient below one: take one more bit from below and lower the exponent.
  assign mant     = quo_q[DIV_BITS-1] ? quo_q[DIV_BITS-2:2] : quo_q[DIV_BITS-3:1];
  assign pack_exp = quo_q[DIV_BITS-1] ? e_q : (e_q - 8'd1);

  // rem_diff < divisor, so its top bit is always clear; quo_q[0] and
  // e_pre's carry bit never reach the result.
  assign unused_bits = ^{rem_diff[LOG_W], quo_q[0], e_pre[EXP_W]};

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      ly_q   <= '0;
      sign_q <= 1'b0;
      e_q    <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      quo_q  <= '0;
      err_q  <= 1'b0;
      zero_q <= 1'b0;
      z_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q <= fp_t'(x);
            y_q <= fp_t'(y);
          end
        end
        CLASS: begin
          err_q  <= bad_in;
          zero_q <= 1'b0;
        end
        LOGX: begin
          // Ly is final until the x pass overwrites the unit at this edge.
          if (log_start) ly_q <= log_result;
        end
        PRENORM: begin
          sign_q <= ly_q[LOG_W-1] ^ log_result[LOG_W-1];
          e_q    <= e_pre[EXP_W-1:0];
          rem_q  <= {1'b0, norm_y};
          dsr_q  <= norm_x;
          quo_q  <= '0;
          zero_q <= (ly_q == '0);
        end
        DIV: begin
          rem_q <= {rem_diff[LOG_W-1:0], 1'b0};
          quo_q <= {quo_q[DIV_BITS-2:0], rem_ge};
        end
        PACK: begin
          if (err_q)       z_q <= QNAN;
          else if (zero_q) z_q <= '0;
          else             z_q <= {sign_q, pack_exp, mant};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logxy.sv
// tb_logxy -- self-checking bench for logxy using a result scoreboard.
module tb_logxy;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;
  logic        err;

  always #5 clk = ~clk;

  logxy dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .err       (err)
  );

  typedef struct {
    logic [31:0] z;
    logic        err;
    int          lat;   // 0: latency not checked
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, want);
    end
  endtask

  // Drive one operand pair and push its expected result.
  task automatic issue(input logic [31:0] xv, input logic [31:0] yv,
                       input logic [31:0] zv, input logic ev, input int lat,
                       input bit from_reset);
    int guard;
    guard = 0;
    if (!from_reset) begin
      @(negedge clk);
      while (in_ready !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) check("idle_timeout", {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b1;
    x        = xv;
    y        = yv;
    if (from_reset) rst = 1'b0;
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
    x        = $urandom;
    y        = $urandom;
    check("accepted", {31'b0, in_ready}, 32'd0);
    sb.push_back('{zv, ev, lat});
  endtask

  // Wait for the result, compare against the scoreboard, then hand it off.
  task automatic collect(input bit early_ready, input bit poke);
    exp_t        e;
    int          el;
    logic [31:0] z0;
    bit          ok;
    if (early_ready) out_ready = 1'b1;
    el = 0;
    do begin
      @(negedge clk);
      el = cyc - acc_cyc;
      if (poke && el == 10) begin
        check("busy_in_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1;
        x        = 32'h40000000;
        y        = 32'h40800000;
      end
      if (poke && el == 11) in_valid = 1'b0;
    end while (out_valid !== 1'b1 && el < 300);
    check("out_valid_seen", {31'b0, out_valid}, 32'd1);
    e = sb.pop_front();
    if (e.lat != 0) check("latency", el, e.lat);
    check("z", z, e.z);
    check("err", {31'b0, err}, {31'b0, e.err});
    if (!early_ready) begin
      z0 = z;
      ok = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (z !== z0 || out_valid !== 1'b1 || in_ready !== 1'b0 || err !== e.err) ok = 1'b0;
      end
      check("hold_stable", {31'b0, ok}, 32'd1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop_after_hs", {31'b0, out_valid}, 32'd0);
    check("ready_after_hs", {31'b0, in_ready}, 32'd1);
    if (poke) begin
      ok = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
      end
      check("busy_input_not_queued", {31'b0, ok}, 32'd1);
    end
  endtask

  task automatic op(input logic [31:0] xv, input logic [31:0] yv,
                    input logic [31:0] zv, input logic ev, input int lat,
                    input bit early_ready, input bit poke);
    issue(xv, yv, zv, ev, lat, 1'b0);
    collect(early_ready, poke);
  endtask

  initial begin
    bit quiet;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_err",       {31'b0, err},       32'd0);
    check("rst_z",         z,                  32'd0);

    // Accept on the very first edge after release: log_2(8) = 3
    issue(32'h40000000, 32'h41000000, 32'h40400000, 1'b0, 75, 1'b1);
    collect(1'b0, 1'b0);

    op(32'h40800000, 32'h40000000, 32'h3F000000, 1'b0, 75, 1'b0, 1'b0); // log_4(2)   = 0.5
    op(32'h41000000, 32'h3F000000, 32'hBEAAAAAA, 1'b0, 75, 1'b1, 1'b0); // log_8(0.5) = -1/3
    op(32'h40000000, 32'h3F800000, 32'h00000000, 1'b0, 0,  1'b0, 1'b0); // log_2(1)   = 0
    op(32'h3F800000, 32'h40000000, 32'h7FC00000, 1'b1, 2,  1'b0, 1'b0); // base 1.0
    op(32'h40000000, 32'hC0000000, 32'h7FC00000, 1'b1, 2,  1'b1, 1'b0); // negative y
    op(32'h7FC00001, 32'h40000000, 32'h7FC00000, 1'b1, 2,  1'b0, 1'b0); // NaN x
    op(32'h00000000, 32'h40000000, 32'h7FC00000, 1'b1, 2,  1'b1, 1'b0); // zero x
    op(32'h40000000, 32'h7F800000, 32'h7FC00000, 1'b1, 2,  1'b1, 1'b0); // Inf y
    op(32'h00000001, 32'h41000000, 32'h7FC00000, 1'b1, 2,  1'b1, 1'b0); // denormal x
    op(32'h40000000, 32'h40800000, 32'h40000000, 1'b0, 75, 1'b1, 1'b0); // log_2(4)    = 2
    op(32'h40800000, 32'h41000000, 32'h3FC00000, 1'b0, 75, 1'b0, 1'b1); // log_4(8)    = 1.5, busy poke
    op(32'h3F000000, 32'h41000000, 32'hC0400000, 1'b0, 75, 1'b1, 1'b0); // log_0.5(8)  = -3
    op(32'h41800000, 32'h40000000, 32'h3E800000, 1'b0, 75, 1'b1, 1'b0); // log_16(2)   = 0.25
    op(32'h40000000, 32'h3E800000, 32'hC0000000, 1'b0, 75, 1'b1, 1'b0); // log_2(0.25) = -2

    // Reset 40 cycles into an operation discards it at once.
    issue(32'h40000000, 32'h41000000, 32'h40400000, 1'b0, 75, 1'b0);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_in_ready",  {31'b0, in_ready},  32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_z",         z,                  32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    quiet = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
    end
    check("abort_no_result", {31'b0, quiet}, 32'd1);

    // Back-to-back operations after the abort.
    op(32'h40000000, 32'h41000000, 32'h40400000, 1'b0, 75, 1'b1, 1'b0);
    op(32'h41000000, 32'h3F000000, 32'hBEAAAAAA, 1'b0, 75, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
